// File: rtl/bin2asc_tx.sv
// Signed binary to decimal ASCII streamer: double-dabble conversion, then one character
// per TX handshake ('-', digits without leading zeros, optional CR LF; "ERR" on error).
module bin2asc_tx #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5,
    parameter bit          EOL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] result_i,
    input  logic             err_i,
    input  logic             result_valid,
    output logic             result_ready,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_done,
    output logic             busy
);
    localparam int unsigned QDepth = DIGITS + 3;
    localparam int unsigned IW     = $clog2(QDepth);
    localparam int unsigned CW     = $clog2(WIDTH + 1);
    localparam int unsigned BW     = 4 * DIGITS;

    typedef enum logic [2:0] {StIdle, StConv, StLoad, StSend, StWait} state_e;
    state_e state_q, state_d;

    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BW-1:0]    bcd_q, bcd_d, bcd_adj, bcd_shift;
    logic             neg_q, neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       queue_q [QDepth];
    logic [7:0]       queue_d [QDepth];
    logic [7:0]       conv_q  [QDepth];
    logic [IW-1:0]    conv_n, last_q, last_d, rd_q, rd_d;
    logic             final_q, final_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             conv_last, started;

    assign conv_last = (cnt_q == CW'(WIDTH - 1));

    // Add-3 correction on every BCD nibble, then shift in the next magnitude bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end
    assign bcd_shift = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};

    // Character queue built from the fully converted BCD value.
    always_comb begin
        conv_n  = '0;
        started = 1'b0;
        for (int k = 0; k < int'(QDepth); k++) conv_q[k] = '0;
        if (neg_q) begin
            conv_q[conv_n] = 8'd45;
            conv_n         = conv_n + 1'b1;
        end
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (bcd_shift[4*i +: 4] != 4'd0 || started || i == 0) begin
                started        = 1'b1;
                conv_q[conv_n] = 8'd48 + {4'd0, bcd_shift[4*i +: 4]};
                conv_n         = conv_n + 1'b1;
            end
        end
        if (EOL_EN) begin
            conv_q[conv_n] = 8'd13;
            conv_n         = conv_n + 1'b1;
            conv_q[conv_n] = 8'd10;
            conv_n         = conv_n + 1'b1;
        end
    end

    always_comb begin
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        queue_d   = queue_q;
        last_d    = last_q;
        rd_d      = rd_q;
        final_d   = final_q;
        tx_data_d = tx_data_q;
        unique case (state_q)
            StIdle: begin
                if (result_valid) begin
                    neg_d = result_i[WIDTH-1];
                    mag_d = result_i[WIDTH-1] ? (~result_i + 1'b1) : result_i;
                    bcd_d = '0;
                    cnt_d = '0;
                    rd_d  = '0;
                    if (err_i) begin
                        for (int k = 0; k < int'(QDepth); k++) queue_d[k] = '0;
                        queue_d[0] = 8'd69;
                        queue_d[1] = 8'd82;
                        queue_d[2] = 8'd82;
                        queue_d[3] = EOL_EN ? 8'd13 : 8'd0;
                        queue_d[4] = EOL_EN ? 8'd10 : 8'd0;
                        last_d     = EOL_EN ? IW'(4) : IW'(2);
                    end
                end
            end
            StConv: begin
                mag_d = mag_q << 1;
                bcd_d = bcd_shift;
                cnt_d = cnt_q + 1'b1;
                if (conv_last) begin
                    queue_d = conv_q;
                    last_d  = conv_n - 1'b1;
                end
            end
            StLoad: begin
                tx_data_d = queue_q[rd_q];
                final_d   = (rd_q == last_q);
                rd_d      = rd_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q     <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            last_q    <= '0;
            rd_q      <= '0;
            final_q   <= 1'b0;
            tx_data_q <= '0;
            for (int k = 0; k < int'(QDepth); k++) queue_q[k] <= '0;
        end else begin
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rd_q      <= rd_d;
            final_q   <= final_d;
            tx_data_q <= tx_data_d;
            queue_q   <= queue_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (result_valid) state_d = err_i ? StLoad : StConv;
            StConv:  if (conv_last) state_d = StLoad;
            StLoad:  state_d = StSend;
            StSend:  state_d = StWait;
            StWait:  if (tx_done) state_d = final_q ? StIdle : StLoad;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        result_ready = (state_q == StIdle);
        busy         = (state_q != StIdle);
        tx_start     = (state_q == StSend);
        tx_data      = tx_data_q;
    end

endmodule
